nand_vec_pipe: RTL and testbench
================================

NAND_VEC_PIPE -- requirements
Module: nand_vec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits, legal range 1..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in register stages, legal range 1..8.
REQ-003 SHALL have parameter CNT_W, default 16, width of the completed-transaction counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream offers an operand set.
REQ-007 SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port mode  input  2  operation select, sampled with the operands.
REQ-011 SHALL have port out_valid  output  1  result o is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port o  output  WIDTH  result.
REQ-014 SHALL have port txn_count  output  CNT_W  count of completed output handshakes.

Function
REQ-015 SHALL compute by mode: 00 -> ~(a & b); 01 -> ~(a & a) (NOT a); 10 -> ~(~(a & b)) (AND); 11 -> reduce-NAND ~&a in bit 0, bits WIDTH-1..1 zero.
REQ-016 SHALL build every mode result from 2-input NAND primitives only (no direct &, |, ~ on data outside the primitive).
REQ-017 SHALL define input handshake as in_valid & in_ready and output handshake as out_valid & out_ready, both on the same rising edge.
REQ-018 SHALL advance the whole pipeline when en = ~out_valid | out_ready; when en is low, every stage holds data and valid.
REQ-019 SHALL drive in_ready = en combinationally.
REQ-020 SHALL carry a valid bit per stage; a stage loads valid = 0 (bubble) when the stage before it is empty or, for stage 0, when in_valid is low.
REQ-021 SHALL present a result with latency exactly STAGES cycles from input handshake to out_valid high, provided en stays high.
REQ-022 SHALL compute the result in stage 0; stages 1..STAGES-1 are pure delay.
REQ-023 SHALL hold o and out_valid stable while out_valid is high and out_ready is low.
REQ-024 SHALL sustain one handshake per cycle when out_ready is held high.
REQ-025 SHALL increment txn_count by 1 on each output handshake, saturating at 2^CNT_W-1 (no wrap).
REQ-026 SHALL let simultaneous input and output handshakes in the same cycle proceed together with no lost or duplicated result.

Reset
REQ-027 SHALL, while rst_n is low at a rising clk edge, clear all stage valid bits, stage data and txn_count to 0; o = 0 and out_valid = 0.
REQ-028 SHALL discard all in-flight results when reset is asserted mid-operation; no result accepted before reset appears after it.
REQ-029 SHALL keep in_ready = 1 during and after reset, because out_valid = 0 makes en high.

Structure
REQ-030 SHALL place mode encodings (MODE_NAND, MODE_NOT, MODE_AND, MODE_RNAND) in a shared package nand_pkg.
REQ-031 SHALL instantiate the sub-module nand2_vec (WIDTH-bit bitwise 2-input NAND) for all data operations, including a log-depth tree for the reduce mode.
REQ-032 SHALL implement the stage registers as a generate loop over STAGES.

Verification
REQ-033 SHALL cover: WIDTH=8, STAGES=2, out_ready=1, mode 00, a=8'hF0, b=8'hCC -> o=8'h3F, out_valid high exactly 2 cycles after acceptance.
REQ-034 SHALL cover: mode 01 a=8'hA5 -> 8'h5A; mode 10 a=8'hF0 b=8'hCC -> 8'hC0; mode 11 a=8'hFF -> 8'h00; mode 11 a=8'hFE -> 8'h01.
REQ-035 SHALL cover: 4 back-to-back inputs, out_ready low for 3 cycles after first out_valid -> o held stable, in_ready low, all 4 results delivered in order, txn_count=4.
REQ-036 SHALL cover: rst_n low for 1 cycle with 2 results in flight -> out_valid=0 next cycle, txn_count=0, no stale result ever emitted.
REQ-037 SHALL cover: CNT_W=2, 5 handshakes -> txn_count reads 1,2,3,3,3.
REQ-038 SHALL cover: WIDTH=1, STAGES=1 exhaustive a,b in {0,1} for mode 00 -> o=1,1,1,0 for ab=00,01,10,11, latency 1.

Source files
------------

// File: rtl/nand_pkg.sv
// nand_pkg: operation encodings shared by the NAND vector pipeline and its users.
package nand_pkg;
    localparam logic [1:0] MODE_NAND  = 2'b00;
    localparam logic [1:0] MODE_NOT   = 2'b01;
    localparam logic [1:0] MODE_AND   = 2'b10;
    localparam logic [1:0] MODE_RNAND = 2'b11;
endpackage

// File: rtl/nand2_vec.sv
// nand2_vec: bitwise 2-input NAND, the only data primitive of the pipeline.
module nand2_vec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] z_o
);
    assign z_o = ~(x_i & y_i);
endmodule

// File: rtl/nand_vec_pipe.sv
// nand_vec_pipe: NAND-built vector ALU in stage 0 followed by a valid/ready delay pipeline.
module nand_vec_pipe
    import nand_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [CNT_W-1:0] txn_count
);
    localparam int LOG = $clog2(WIDTH);
    localparam int P   = 1 << LOG;

    logic [WIDTH-1:0] n_ab, n_aa, and_ab, res_d;
    logic [P-1:0]     a_pad;
    logic             all_and, rnand, en;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    nand2_vec #(.WIDTH(WIDTH)) u_nab (.x_i(a),    .y_i(b),    .z_o(n_ab));
    nand2_vec #(.WIDTH(WIDTH)) u_naa (.x_i(a),    .y_i(a),    .z_o(n_aa));
    nand2_vec #(.WIDTH(WIDTH)) u_and (.x_i(n_ab), .y_i(n_ab), .z_o(and_ab));

    // Pad with ones so the AND tree is a full power of two without changing the result
    always_comb begin
        a_pad = '1;
        a_pad[WIDTH-1:0] = a;
    end

    for (genvar k = 0; k < LOG; k++) begin : g_lvl
        localparam int N = P >> (k + 1);
        logic [2*N-1:0] src;
        logic [N-1:0]   ev, od, nd, v;
        if (k == 0) begin : g_first
            assign src = a_pad;
        end else begin : g_next
            assign src = g_lvl[k-1].v;
        end
        for (genvar j = 0; j < N; j++) begin : g_pair
            assign ev[j] = src[2*j];
            assign od[j] = src[2*j+1];
        end
        nand2_vec #(.WIDTH(N)) u_n (.x_i(ev), .y_i(od), .z_o(nd));
        nand2_vec #(.WIDTH(N)) u_i (.x_i(nd), .y_i(nd), .z_o(v));
        if (k == LOG - 1) begin : g_root
            assign all_and = v[0];
        end
    end

    if (LOG == 0) begin : g_single
        assign all_and = a_pad[0];
    end

    nand2_vec #(.WIDTH(1)) u_rn (.x_i(all_and), .y_i(all_and), .z_o(rnand));

    assign res_d = (mode == MODE_NAND) ? n_ab :
                   (mode == MODE_NOT)  ? n_aa :
                   (mode == MODE_AND)  ? and_ab : WIDTH'(rnand);

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        logic [WIDTH-1:0] data_q, data_d;
        logic             vld_q, vld_d;
        if (s == 0) begin : g_head
            assign data_d = res_d;
            assign vld_d  = in_valid;
        end else begin : g_tail
            assign data_d = g_stg[s-1].data_q;
            assign vld_d  = g_stg[s-1].vld_q;
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (en) begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].vld_q;
    assign o         = g_stg[STAGES-1].data_q;

    assign cnt_d = (out_valid & out_ready & (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign txn_count = cnt_q;
endmodule

// File: tb/tb_nand_vec_pipe.sv
// tb_nand_vec_pipe: directed and randomized checks of nand_vec_pipe in three configurations.
module tb_nand_vec_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    logic        rst_n0, iv0, ir0, ov0, or0;
    logic [7:0]  a0, b0, o0;
    logic [1:0]  m0;
    logic [15:0] cnt0;

    logic        rst_n1, iv1, ir1, ov1, or1;
    logic [7:0]  a1, b1, o1;
    logic [1:0]  m1;
    logic [1:0]  cnt1;

    logic        rst_n2, iv2, ir2, ov2, or2;
    logic [0:0]  a2, b2, o2;
    logic [1:0]  m2;
    logic [15:0] cnt2;

    nand_vec_pipe u0 (.clk(clk), .rst_n(rst_n0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
                      .mode(m0), .out_valid(ov0), .out_ready(or0), .o(o0), .txn_count(cnt0));
    nand_vec_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n1), .in_valid(iv1),
                      .in_ready(ir1), .a(a1), .b(b1), .mode(m1), .out_valid(ov1), .out_ready(or1),
                      .o(o1), .txn_count(cnt1));
    nand_vec_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n2), .in_valid(iv2),
                      .in_ready(ir2), .a(a2), .b(b2), .mode(m2), .out_valid(ov2), .out_ready(or2),
                      .o(o2), .txn_count(cnt2));

    function automatic logic [7:0] ref_op(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        case (m)
            2'd0:    return ~(x & y);
            2'd1:    return ~x;
            2'd2:    return x & y;
            default: return {7'd0, ~&x};
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic reset0;
        rst_n0 = 1'b0;
        iv0 = 1'b0;
        step();
        rst_n0 = 1'b1;
    endtask

    task automatic test_reset;
        total++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", ov0); else pass_cnt++;
        total++; if (o0 !== 8'h00) $display("FAIL reset_o: got %h want 00", o0); else pass_cnt++;
        total++; if (cnt0 !== 16'd0) $display("FAIL reset_txn_count: got %0d want 0", cnt0); else pass_cnt++;
        total++; if (ir0 !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", ir0); else pass_cnt++;
        rst_n0 = 1'b1;
        step();
        total++; if (ir0 !== 1'b1) $display("FAIL post_reset_in_ready: got %0b want 1", ir0); else pass_cnt++;
    endtask

    task automatic test_latency;
        or0 = 1'b1; iv0 = 1'b1; a0 = 8'hF0; b0 = 8'hCC; m0 = 2'b00;
        #1;
        total++; if (ir0 !== 1'b1) $display("FAIL lat_in_ready: got %0b want 1", ir0); else pass_cnt++;
        step();
        iv0 = 1'b0;
        total++; if (ov0 !== 1'b0) $display("FAIL lat_early_valid: got %0b want 0 after 1 cycle", ov0); else pass_cnt++;
        step();
        total++; if (ov0 !== 1'b1) $display("FAIL lat_valid: got %0b want 1 after 2 cycles", ov0); else pass_cnt++;
        total++; if (o0 !== 8'h3F) $display("FAIL lat_nand: got %h want 3f", o0); else pass_cnt++;
        step();
        total++; if (ov0 !== 1'b0) $display("FAIL lat_drain: got %0b want 0", ov0); else pass_cnt++;
    endtask

    task automatic test_modes;
        logic [1:0] tm [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
        logic [7:0] ta [4] = '{8'hA5, 8'hF0, 8'hFF, 8'hFE};
        logic [7:0] tb [4] = '{8'h00, 8'hCC, 8'h00, 8'h00};
        logic [7:0] te [4] = '{8'h5A, 8'hC0, 8'h00, 8'h01};
        or0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv0 = 1'b1; m0 = tm[i]; a0 = ta[i]; b0 = tb[i];
            step();
            iv0 = 1'b0;
            step();
            total++; if (ov0 !== 1'b1 || o0 !== te[i])
                $display("FAIL mode_%0d: got valid=%0b o=%h want valid=1 o=%h", i, ov0, o0, te[i]); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4], vb [4];
        logic [1:0] vm [4];
        logic [7:0] got [$];
        int idx = 0;
        logic hs_in, hs_out;
        for (int i = 0; i < 4; i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom); vm[i] = 2'($urandom);
        end
        reset0();
        for (int c = 0; c < 16; c++) begin
            or0 = (c >= 5);
            iv0 = (idx < 4);
            if (idx < 4) begin a0 = va[idx]; b0 = vb[idx]; m0 = vm[idx]; end
            #1;
            if (c >= 2 && c <= 4) begin
                total++; if (ov0 !== 1'b1 || o0 !== ref_op(vm[0], va[0], vb[0]))
                    $display("FAIL b2b_hold_%0d: got valid=%0b o=%h want valid=1 o=%h", c, ov0, o0, ref_op(vm[0], va[0], vb[0]));
                else pass_cnt++;
                total++; if (ir0 !== 1'b0) $display("FAIL b2b_in_ready_%0d: got %0b want 0", c, ir0); else pass_cnt++;
            end
            hs_in  = iv0 && ir0;
            hs_out = ov0 && or0;
            if (hs_out) got.push_back(o0);
            if (hs_in) idx++;
            step();
        end
        iv0 = 1'b0;
        total++; if (got.size() !== 4) $display("FAIL b2b_count: got %0d results want 4", got.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== ref_op(vm[i], va[i], vb[i]))
                $display("FAIL b2b_order_%0d: got %h want %h", i, got[i], ref_op(vm[i], va[i], vb[i])); else pass_cnt++;
        end
        total++; if (cnt0 !== 16'd4) $display("FAIL b2b_txn_count: got %0d want 4", cnt0); else pass_cnt++;
    endtask

    task automatic test_reset_flush;
        reset0();
        or0 = 1'b0; iv0 = 1'b1; a0 = 8'h12; b0 = 8'h34; m0 = 2'b00;
        step();
        a0 = 8'h56;
        step();
        iv0 = 1'b0;
        total++; if (ov0 !== 1'b1) $display("FAIL flush_inflight: got %0b want 1", ov0); else pass_cnt++;
        rst_n0 = 1'b0;
        step();
        total++; if (ov0 !== 1'b0) $display("FAIL flush_valid: got %0b want 0", ov0); else pass_cnt++;
        total++; if (cnt0 !== 16'd0) $display("FAIL flush_txn_count: got %0d want 0", cnt0); else pass_cnt++;
        total++; if (ir0 !== 1'b1) $display("FAIL flush_in_ready: got %0b want 1", ir0); else pass_cnt++;
        rst_n0 = 1'b1; or0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++; if (ov0 !== 1'b0) $display("FAIL flush_stale_%0d: got valid=%0b o=%h want valid=0", c, ov0, o0); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_random;
        logic [7:0] q [$];
        logic [7:0] want, prev_o;
        logic prev_stall = 1'b0;
        int n_out = 0;
        reset0();
        for (int i = 0; i < 420; i++) begin
            iv0 = (i < 400) && ($urandom_range(0, 3) != 0);
            or0 = (i >= 400) || ($urandom_range(0, 2) != 0);
            a0 = 8'($urandom); b0 = 8'($urandom); m0 = 2'($urandom);
            #1;
            if (prev_stall) begin
                total++; if (ov0 !== 1'b1 || o0 !== prev_o)
                    $display("FAIL rnd_hold_%0d: got valid=%0b o=%h want valid=1 o=%h", i, ov0, o0, prev_o); else pass_cnt++;
            end
            total++; if (ir0 !== (!ov0 || or0))
                $display("FAIL rnd_in_ready_%0d: got %0b want %0b", i, ir0, !ov0 || or0); else pass_cnt++;
            if (ov0 && or0) begin
                n_out++;
                if (q.size() == 0) begin
                    total++; $display("FAIL rnd_spurious_%0d: got o=%h want no result", i, o0);
                end else begin
                    want = q.pop_front();
                    total++; if (o0 !== want) $display("FAIL rnd_data_%0d: got %h want %h", i, o0, want); else pass_cnt++;
                end
            end
            if (iv0 && ir0) q.push_back(ref_op(m0, a0, b0));
            prev_stall = ov0 && !or0;
            prev_o = o0;
            step();
        end
        total++; if (q.size() !== 0) $display("FAIL rnd_lost: got %0d undelivered want 0", q.size()); else pass_cnt++;
        total++; if (cnt0 !== 16'(n_out)) $display("FAIL rnd_txn_count: got %0d want %0d", cnt0, n_out); else pass_cnt++;
    endtask

    task automatic test_saturate;
        int sent = 0, k = 0;
        int want;
        logic hs;
        or1 = 1'b1; m1 = 2'b00; b1 = 8'h00;
        for (int c = 0; c < 12; c++) begin
            iv1 = (sent < 5);
            a1 = 8'($urandom);
            #1;
            hs = ov1 && or1;
            if (iv1 && ir1) sent++;
            step();
            if (hs) begin
                k++;
                want = (k < 3) ? k : 3;
                total++; if (cnt1 !== 2'(want)) $display("FAIL sat_%0d: got %0d want %0d", k, cnt1, want); else pass_cnt++;
            end
        end
        iv1 = 1'b0;
        total++; if (k !== 5) $display("FAIL sat_handshakes: got %0d want 5", k); else pass_cnt++;
    endtask

    task automatic test_width1;
        logic [1:0] ab;
        logic want;
        or2 = 1'b1; m2 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a2 = ab[1]; b2 = ab[0]; iv2 = 1'b1;
            want = (ab == 2'b11) ? 1'b0 : 1'b1;
            step();
            iv2 = 1'b0;
            total++; if (ov2 !== 1'b1 || o2 !== want)
                $display("FAIL w1_ab%0d%0d: got valid=%0b o=%0b want valid=1 o=%0b", ab[1], ab[0], ov2, o2, want); else pass_cnt++;
            step();
        end
    endtask

    initial begin
        rst_n0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0; m0 = '0;
        rst_n1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; m1 = '0;
        rst_n2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; m2 = '0;
        step();
        step();
        rst_n1 = 1'b1; rst_n2 = 1'b1;
        test_reset();
        test_latency();
        test_modes();
        test_back_to_back();
        test_reset_flush();
        test_random();
        test_saturate();
        test_width1();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
